// File: rtl/sipo_nbit_rx_if.sv
// rtl/sipo_nbit_rx_if.sv - serial link receive side and parallel word handshake bundle
interface sipo_nbit_rx_if #(
    parameter int N = 4
);
    logic         d_in;
    logic         en_in;
    logic         start_in;
    logic         ready_in;
    logic [N-1:0] q_out;
    logic         valid_out;
    logic         busy_out;
    logic         overrun_out;
    logic         frame_err_out;

    // Link and consumer side: drives serial bits and ready, observes words and status.
    modport master (
        output d_in,
        output en_in,
        output start_in,
        output ready_in,
        input  q_out,
        input  valid_out,
        input  busy_out,
        input  overrun_out,
        input  frame_err_out
    );

    // Receiver side.
    modport slave (
        input  d_in,
        input  en_in,
        input  start_in,
        input  ready_in,
        output q_out,
        output valid_out,
        output busy_out,
        output overrun_out,
        output frame_err_out
    );
endinterface

// File: rtl/sipo_nbit_rx.sv
// rtl/sipo_nbit_rx.sv - LSB-first serial-in parallel-out receiver with valid/ready output
module sipo_nbit_rx #(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          reset_al_in,
    sipo_nbit_rx_if.slave bus
);
    localparam int CNT_W = $clog2(N);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     shreg;
    logic [N-1:0]     q_r;
    logic             valid_r;
    logic             overrun_r;
    logic             frame_err_r;

    logic             last_bit;
    logic [N-1:0]     word_next;

    // Decode the capture that completes a word; the new bit enters at the MSB
    // so the first received bit has reached the LSB after N captures.
    always_comb begin
        word_next = {bus.d_in, shreg[N-1:1]};
        last_bit  = 1'b0;
        if (bus.en_in && !bus.start_in && (state == SHIFT) &&
            (count == CNT_W'(N - 1))) begin
            last_bit = 1'b1;
        end
    end

    // Frame state, bit counter and shift register; start_in always begins a
    // fresh word, aborting any partial one.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state       <= IDLE;
            count       <= '0;
            shreg       <= '0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (bus.en_in) begin
                case (state)
                    IDLE: begin
                        if (bus.start_in) begin
                            shreg <= {bus.d_in, {(N-1){1'b0}}};
                            count <= CNT_W'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (bus.start_in) begin
                            shreg       <= {bus.d_in, {(N-1){1'b0}}};
                            count       <= CNT_W'(1);
                            frame_err_r <= 1'b1;
                        end else if (last_bit) begin
                            shreg <= word_next;
                            count <= '0;
                            state <= IDLE;
                        end else begin
                            shreg <= word_next;
                            count <= count + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    // Output register: load on completion if the slot is free or being
    // accepted this edge, otherwise drop the new word and flag overrun.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            q_r       <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (last_bit) begin
                if (!valid_r || bus.ready_in) begin
                    q_r     <= word_next;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && bus.ready_in) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign bus.q_out         = q_r;
    assign bus.valid_out     = valid_r;
    assign bus.busy_out      = (state == SHIFT);
    assign bus.overrun_out   = overrun_r;
    assign bus.frame_err_out = frame_err_r;
endmodule
